// File: rtl/mdu.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, HI/LO registers.
// Optional MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle 64-bit product and skip CALC.
module mdu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Start,
   input  logic [2:0]  MduOp,
   input  logic [31:0] DataIn1,
   input  logic [31:0] DataIn2,
   input  logic        HiLoSel,
   output logic [31:0] MduResult,
   output logic        Busy,
   output logic        Done
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] mag_q, mag_d, orig_q, orig_d, rem_q, rem_d;
   logic [63:0] acc_q, acc_d;
   logic        is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic        dz_q, dz_d, done_q, done_d;

   logic        op_signed, op_mul, op_div, sign_a, sign_b, div_ge;
   logic [31:0] abs_a, abs_b, div_diff, quo_fix, rem_fix;
   logic [32:0] mul_sum, div_shift;
   logic [63:0] prod_fix;

   // Datapath: operand magnitudes, one iteration step, and final sign correction.
   always_comb begin
      op_signed = (MduOp == OP_MULT) || (MduOp == OP_DIV);
      op_mul    = (MduOp == OP_MULT) || (MduOp == OP_MULTU);
      op_div    = (MduOp == OP_DIV)  || (MduOp == OP_DIVU);
      sign_a    = op_signed & DataIn1[31];
      sign_b    = op_signed & DataIn2[31];
      abs_a     = sign_a ? (~DataIn1 + 32'd1) : DataIn1;
      abs_b     = sign_b ? (~DataIn2 + 32'd1) : DataIn2;
      // acc_q holds {partial product, remaining multiplier bits} or {unused, dividend/quotient}.
      mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
      div_shift = {rem_q, acc_q[31]};
      div_ge    = div_shift >= {1'b0, mag_q};
      div_diff  = div_shift[31:0] - mag_q;
      prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
      quo_fix   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      rem_fix   = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mag_d     = mag_q;
      orig_d    = orig_q;
      rem_d     = rem_q;
      acc_d     = acc_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (op_mul || op_div) begin
                  mag_d     = op_mul ? abs_a : abs_b;
                  acc_d     = {32'd0, (op_mul ? abs_b : abs_a)};
                  rem_d     = '0;
                  cnt_d     = '0;
                  is_div_d  = op_div;
                  neg_d     = sign_a ^ sign_b;
                  neg_rem_d = sign_a;
                  dz_d      = op_div && (DataIn2 == 32'd0);
                  orig_d    = DataIn1;
                  state_d   = S_CALC;
`ifdef MDU_FAST_MUL_EN
                  if (op_mul) begin
                     acc_d   = {32'd0, abs_a} * {32'd0, abs_b};
                     state_d = S_FIX;
                  end
`endif
               end else if (MduOp == OP_MTHI) begin
                  hi_d = DataIn1;
               end else if (MduOp == OP_MTLO) begin
                  lo_d = DataIn1;
               end
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               rem_d = div_ge ? div_diff : div_shift[31:0];
               acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            // A zero divisor yields an all-ones quotient; the dividend is returned as-is in HI.
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (dz_q) begin
               hi_d = orig_q;
               lo_d = 32'hFFFF_FFFF;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         mag_q     <= '0;
         orig_q    <= '0;
         rem_q     <= '0;
         acc_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         mag_q     <= mag_d;
         orig_q    <= orig_d;
         rem_q     <= rem_d;
         acc_q     <= acc_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
      end
   end

   assign MduResult = HiLoSel ? hi_q : lo_q;
   assign Busy      = (state_q != S_IDLE);
   assign Done      = done_q;

endmodule
